zuc_sbox_sched: RTL and testbench
=================================

# zuc_sbox_sched

Shared S-box scheduler for the ZUC nonlinear function F. It arbitrates round-robin between two 32-bit lookup requesters, for example the W1 and W2 paths of F or two cipher lanes. Each granted word goes through the 32-bit S transform S(x) = S0(x[31:24]) ‖ S1(x[23:16]) ‖ S0(x[15:8]) ‖ S1(x[7:0]) using one dual-port S0 ROM and one dual-port S1 ROM, both synchronous. The result is returned on a valid/ready stream tagged with the requester id. Throughput is one word per cycle.

## Interface
- `CNT_W`, default 16: width of the optional statistics counters.
- `RAM_STYLE`, default "distributed": forwarded to both S-box ROMs.
- `clk` input, 1: single clock.
- `rst` input, 1: asynchronous reset, active-high.
- `s0_valid` input, 1: requester 0 word valid.
- `s0_ready` output, 1: requester 0 word accepted this cycle.
- `s0_data` input, 32: requester 0 word.
- `s1_valid`, `s1_ready`, `s1_data`: requester 1, same as requester 0.
- `m_valid` output, 1: result valid.
- `m_ready` input, 1: downstream accepts the result.
- `m_data` output, 32: S(x) of the granted word.
- `m_id` output, 1: requester index of `m_data`.
- `grant_cnt0` output, `CNT_W`: present only with the statistics macro (see Configuration).
- `grant_cnt1` output, `CNT_W`: present only with the statistics macro.
- `stall_cnt` output, `CNT_W`: present only with the statistics macro.

## Operation
- `accept = !m_valid || m_ready`. The output slot is free or is draining this cycle.
- Arbitration is combinational round-robin on `rr` (1 bit; value = requester with priority).
  - Both valid: grant `rr`.
  - One valid: grant that requester.
  - None valid: no grant.
- `sX_ready = accept && grant==X`. Ready depends combinationally on `m_ready`, `m_valid` and both `s*_valid`.
- `fire = accept && (s0_valid || s1_valid)`.
- On `fire`:
  - ROM `rd` is asserted for both ROMs.
  - ROM addresses are the granted word's four bytes: S0 ports get bytes [31:24] and [15:8]; S1 ports get bytes [23:16] and [7:0].
  - `id_q <= grant`.
  - `rr <= ~grant`.
- With no `fire`, ROM `rd` is low. ROM output registers and `id_q` hold, so a stalled result stays stable.
- `m_valid` next-state:
  - set on `fire`;
  - else cleared on `m_ready`;
  - else held.
- `m_data` is the concatenation `{S0 y0, S1 y0, S0 y1, S1 y1}` when `m_valid=1`. It is forced to 0 when `m_valid=0`.
- `m_id = m_valid ? id_q : 0`.

## Timing
- Latency: an accepted word at edge N appears on `m_data` after edge N, i.e. one cycle.
- Back-to-back: with `m_ready=1` held high, one word is accepted and one result delivered every cycle.
- Output stall: while `m_valid && !m_ready`, both `sX_ready` are 0, and `m_data` and `m_id` are stable.
- Simultaneous drain and accept (`m_valid && m_ready && fire`): `m_valid` stays 1 and the new result replaces the old one on the next edge.
- Reset values:
  - `m_valid=0`, `m_data=0`, `m_id=0`;
  - `rr=0` (requester 0 wins the first contention);
  - `s0_ready` and `s1_ready` follow `accept=1` while in reset. They are ignored; no transfer occurs while `rst` is high.
- Reset mid-operation: an in-flight result is discarded and `m_valid` drops asynchronously. No result is emitted after reset release until a new accept.
- While `rst` is high, `fire` is gated to 0.

## Configuration
- Macro: `ZUC_SBOX_SCHED_STATS_EN`.
- Defined:
  - `grant_cnt0` and `grant_cnt1` increment on each `fire` granted to that requester.
  - `stall_cnt` increments on each cycle with `m_valid && !m_ready`.
  - All three saturate at all-ones and reset to 0.
- Undefined: the counter ports and their logic are absent. The remaining behaviour is identical.

## Structure
- Shared package `zuc_pkg`:
  - `ZUC_WORD_W=32`;
  - `zuc_word_t`;
  - byte-lane constants for the S0/S1 interleave, used by the F function too.
- Sub-modules: one `zuc_s0` and one `zuc_s1`, each instantiated with `sync=1` and `ram_style=RAM_STYLE`.
- The round-robin arbiter is a natural sub-module, `zuc_rr_arb2`, with inputs req[1:0], rr and accept, and outputs grant and fire.

## Test plan
- Reset, then `s0_data=0x00000000` valid with `m_ready=1` → next cycle `m_valid=1`, `m_data=0x3e553e55`, `m_id=0`.
- `s1_data=0x01010101` alone → `m_data=0x72c272c2`, `m_id=1`.
- Both requesters valid continuously, `m_ready=1` → grants alternate 0,1,0,1 starting with 0, and `m_id` alternates one cycle later.
- Result pending, `m_ready=0` for 5 cycles → `s0_ready` and `s1_ready` are 0, `m_data` and `m_id` are constant, and `stall_cnt=5` with the macro defined.
- `rst` pulsed while `m_valid=1` → `m_valid`, `m_data` and `m_id` go to 0 immediately, and after release requester 0 wins the first contention.
- With the macro defined, 10 grants to requester 0 → `grant_cnt0=10`. With `CNT_W=4` and 20 grants, the counter saturates at 15.

Source files
------------

// File: rtl/zuc_pkg.sv
// Shared ZUC definitions: word type and the byte-lane layout of the 32-bit S transform.
package zuc_pkg;

  localparam int unsigned ZUC_WORD_W = 32;

  typedef logic [ZUC_WORD_W-1:0] zuc_word_t;
  typedef logic [7:0]            zuc_byte_t;

  // S(x) interleaves the boxes: S0 on lanes 3 and 1, S1 on lanes 2 and 0.
  localparam int unsigned LANE_S0_HI = 3;
  localparam int unsigned LANE_S1_HI = 2;
  localparam int unsigned LANE_S0_LO = 1;
  localparam int unsigned LANE_S1_LO = 0;

  function automatic zuc_byte_t zuc_lane(input zuc_word_t w, input int unsigned idx);
    return w[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/zuc_sbox_sched_if.sv
// Request/result bundle of the shared S-box scheduler (two requesters, one result stream).
interface zuc_sbox_sched_if;
  import zuc_pkg::*;

  logic      s0_valid;
  logic      s0_ready;
  zuc_word_t s0_data;
  logic      s1_valid;
  logic      s1_ready;
  zuc_word_t s1_data;
  logic      m_valid;
  logic      m_ready;
  zuc_word_t m_data;
  logic      m_id;

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, m_ready,
    input  s0_ready, s1_ready, m_valid, m_data, m_id
  );

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, m_ready,
    output s0_ready, s1_ready, m_valid, m_data, m_id
  );

endinterface

// File: rtl/zuc_rr_arb2.sv
// Two-way round-robin arbiter; rr names the requester that wins a contention.
module zuc_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic       accept,
  output logic       grant,
  output logic       fire
);

  always_comb begin
    grant = 1'b0;
    unique case (req)
      2'b11:   grant = rr;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  assign fire = accept && (|req);

endmodule

// File: rtl/zuc_s0.sv
// Dual-port ZUC S0 ROM; registered read when sync is set or a block ROM is requested.
module zuc_s0 #(
  parameter bit    sync      = 1'b1,
  parameter string ram_style = "distributed"
) (
  input  logic       clk,
  input  logic       rd_a,
  input  logic [7:0] addr_a,
  output logic [7:0] data_a,
  input  logic       rd_b,
  input  logic [7:0] addr_b,
  output logic [7:0] data_b
);

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] Table = {
    128'h3e725b47cae0003304d1549809b96dcb, 128'h7b1bf932af9d6aa5b82dfc1d08530390,
    128'h4d4e8499e4ced991ddb685488b296eac, 128'hcdc1f81e734369c6b5bdfd396320d438,
    128'h767db2a7cfed57c5f32cbb142106559b, 128'he3ef5e314f7f5aa40d8251495fba581c,
    128'h4a16d517a892241f8cffd8ae2e01d3ad, 128'h3b4bda46ebc9de9a8f87d73a806f2fc8,
    128'hb1b437f70a2213287ccc3c89c7c39656, 128'h07bf7ef00b2b975235417961a64c10fe,
    128'hbc2695888ab0a3fbc01894f2e1e5e95d, 128'hd0dc1166645cec59427512f5749caa23,
    128'h0e86abbe2a02e767e644a26cc2939ff1, 128'hf6fa36d250689e6271153dd640c4e20f,
    128'h8e83776b25053f0c30ea70b7a1e8a965, 128'h8d271adb81b3a0f4457a19dfee783460
  };

  function automatic logic [7:0] lookup(input logic [7:0] a);
    return Table[{~a, 3'b000} +: 8];
  endfunction

  if (sync || ram_style == "block") begin : g_sync
    always_ff @(posedge clk) begin
      if (rd_a) data_a <= lookup(addr_a);
      if (rd_b) data_b <= lookup(addr_b);
    end
  end else begin : g_async
    logic unused_rd;
    assign unused_rd = rd_a ^ rd_b;
    assign data_a    = lookup(addr_a);
    assign data_b    = lookup(addr_b);
  end

endmodule

// File: rtl/zuc_s1.sv
// Dual-port ZUC S1 ROM; registered read when sync is set or a block ROM is requested.
module zuc_s1 #(
  parameter bit    sync      = 1'b1,
  parameter string ram_style = "distributed"
) (
  input  logic       clk,
  input  logic       rd_a,
  input  logic [7:0] addr_a,
  output logic [7:0] data_a,
  input  logic       rd_b,
  input  logic [7:0] addr_b,
  output logic [7:0] data_b
);

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] Table = {
    128'h55c263713bc847869f3cda5b29aafd77, 128'h8cc5940ca61a1300e3a8167240f9f842,
    128'h4426689681d9453e1076c6a78b3943e1, 128'h3ab5562ac06db3052266bfdc0bfa6248,
    128'hdd20110636c9c1cff62752bb69f5d487, 128'h7f844cd29c57a4bc4f9adffed68d7aeb,
    128'h2b53d85ca11417fb23d57d3067730809, 128'heeb7703f61b2198e4ee54b938f5ddba9,
    128'hadf1ae2ecb0dfcf42d466e1d97e8d1e9, 128'h4d37a5755e839eab829db91ce0cd4989,
    128'h01b6bd5824a25f387899159050b895e4, 128'hd091c7ceed0fb46fa0ccf0024a79c3de,
    128'ha3efea51e66b18ec1b2c80f774e7ff21, 128'h5a6a541e41319235c433070aba7e0e34,
    128'h88b1987cf33d606c7bcad31f32650428, 128'h64be859b2f598ad7b025acaf1203e2f2
  };

  function automatic logic [7:0] lookup(input logic [7:0] a);
    return Table[{~a, 3'b000} +: 8];
  endfunction

  if (sync || ram_style == "block") begin : g_sync
    always_ff @(posedge clk) begin
      if (rd_a) data_a <= lookup(addr_a);
      if (rd_b) data_b <= lookup(addr_b);
    end
  end else begin : g_async
    logic unused_rd;
    assign unused_rd = rd_a ^ rd_b;
    assign data_a    = lookup(addr_a);
    assign data_b    = lookup(addr_b);
  end

endmodule

// File: rtl/zuc_sbox_sched.sv
// Round-robin shared S-box scheduler for the ZUC F function, one word per cycle.
// Optional saturating statistics counters are built when ZUC_SBOX_SCHED_STATS_EN is defined.
module zuc_sbox_sched
  import zuc_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter string       RAM_STYLE = "distributed"
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ZUC_SBOX_SCHED_STATS_EN
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  zuc_sbox_sched_if.slave  bus
);

  logic      accept;
  logic      grant;
  logic      arb_fire;
  logic      fire;
  logic      rr_q;
  logic      id_q;
  logic      m_valid_q;
  zuc_word_t word;
  zuc_byte_t s0_hi, s1_hi, s0_lo, s1_lo;

  always_comb begin
    assert (CNT_W > 0);
  end

  assign accept = !m_valid_q || bus.m_ready;

  zuc_rr_arb2 u_arb (
    .req    ({bus.s1_valid, bus.s0_valid}),
    .rr     (rr_q),
    .accept (accept),
    .grant  (grant),
    .fire   (arb_fire)
  );

  // Ready may show during reset, but no transfer is allowed to happen.
  assign fire         = arb_fire && !rst;
  assign bus.s0_ready = accept && !grant;
  assign bus.s1_ready = accept && grant;

  assign word = grant ? bus.s1_data : bus.s0_data;

  zuc_s0 #(
    .sync      (1'b1),
    .ram_style (RAM_STYLE)
  ) u_s0 (
    .clk    (clk),
    .rd_a   (fire),
    .addr_a (zuc_lane(word, LANE_S0_HI)),
    .data_a (s0_hi),
    .rd_b   (fire),
    .addr_b (zuc_lane(word, LANE_S0_LO)),
    .data_b (s0_lo)
  );

  zuc_s1 #(
    .sync      (1'b1),
    .ram_style (RAM_STYLE)
  ) u_s1 (
    .clk    (clk),
    .rd_a   (fire),
    .addr_a (zuc_lane(word, LANE_S1_HI)),
    .data_a (s1_hi),
    .rd_b   (fire),
    .addr_b (zuc_lane(word, LANE_S1_LO)),
    .data_b (s1_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      id_q      <= 1'b0;
      rr_q      <= 1'b0;
    end else if (fire) begin
      m_valid_q <= 1'b1;
      id_q      <= grant;
      rr_q      <= ~grant;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_valid_q ? {s0_hi, s1_hi, s0_lo, s1_lo} : '0;
  assign bus.m_id    = m_valid_q ? id_q : 1'b0;

`ifdef ZUC_SBOX_SCHED_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt1_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (fire && !grant && grant_cnt0_q != CntMax) grant_cnt0_q <= grant_cnt0_q + CNT_W'(1);
      if (fire && grant && grant_cnt1_q != CntMax)  grant_cnt1_q <= grant_cnt1_q + CNT_W'(1);
      if (m_valid_q && !bus.m_ready && stall_cnt_q != CntMax) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_zuc_sbox_sched.sv
// Directed bench for zuc_sbox_sched: scoreboard of expected S(x) results, immediate-assert checks.
module tb_zuc_sbox_sched;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  zuc_sbox_sched_if bus ();

`ifdef ZUC_SBOX_SCHED_STATS_EN
  logic [3:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  zuc_sbox_sched #(
    .CNT_W     (4),
    .RAM_STYLE ("distributed")
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ZUC_SBOX_SCHED_STATS_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .stall_cnt  (stall_cnt),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  exp_t       last;
  int         checks   = 0;
  int         failures = 0;
  int         g0       = 0;
  logic [7:0] byte_pool [5] = '{8'h00, 8'h01, 8'h10, 8'h80, 8'hff};

  // Reference values for the handful of S-box entries the stimulus uses.
  function automatic logic [7:0] s0_ref(input logic [7:0] b);
    case (b)
      8'h00:   return 8'h3e;
      8'h01:   return 8'h72;
      8'h10:   return 8'h7b;
      8'h80:   return 8'hb1;
      8'hff:   return 8'h60;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic [7:0] s1_ref(input logic [7:0] b);
    case (b)
      8'h00:   return 8'h55;
      8'h01:   return 8'hc2;
      8'h10:   return 8'h8c;
      8'h80:   return 8'had;
      8'hff:   return 8'hf2;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic [31:0] sbox_ref(input logic [31:0] w);
    return {s0_ref(w[31:24]), s1_ref(w[23:16]), s0_ref(w[15:8]), s1_ref(w[7:0])};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [31:0] w);
    exp_t e;
    e.id   = id;
    e.data = sbox_ref(w);
    sb.push_back(e);
    if (id == 1'b0) g0++;
  endtask

  task automatic expect_out(input string tag);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_expectation expected=queued_result", tag);
    end else begin
      last = sb.pop_front();
      check({tag, ".valid"}, bus.m_valid, 1'b1);
      check({tag, ".data"}, bus.m_data, last.data);
      check({tag, ".id"}, bus.m_id, last.id);
    end
  endtask

  initial begin
    logic [31:0] w;
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    bus.s0_data  = '0;
    bus.s1_data  = '0;
    bus.m_ready  = 1'b0;

    // Reset state, including no transfer while rst is high.
    #1 rst = 1'b1;
    #1;
    check("rst.m_valid", bus.m_valid, 1'b0);
    check("rst.m_data", bus.m_data, 32'h0);
    check("rst.m_id", bus.m_id, 1'b0);
    check("rst.s0_ready", bus.s0_ready, 1'b1);
    check("rst.s1_ready", bus.s1_ready, 1'b0);
    bus.s0_valid = 1'b1;
    bus.m_ready  = 1'b1;
    step();
    step();
    check("rst.no_fire", bus.m_valid, 1'b0);
    rst = 1'b0;

    // Single word from requester 0, then requester 1.
    bus.s0_data = 32'h0000_0000;
    #1;
    check("t1.s0_ready", bus.s0_ready, 1'b1);
    push(1'b0, bus.s0_data);
    step();
    expect_out("t1");
    check("t1.data_const", bus.m_data, 32'h3e55_3e55);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b1;
    bus.s1_data  = 32'h0101_0101;
    #1;
    check("t2.s1_ready", bus.s1_ready, 1'b1);
    push(1'b1, bus.s1_data);
    step();
    expect_out("t2");
    check("t2.data_const", bus.m_data, 32'h72c2_72c2);
    bus.s1_valid = 1'b0;
    step();
    check("idle.m_valid", bus.m_valid, 1'b0);
    check("idle.m_data", bus.m_data, 32'h0);

    // Continuous contention: grants alternate starting with requester 0.
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    bus.s0_data  = 32'h00ff_01ff;
    bus.s1_data  = 32'h1080_ff10;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("alt.s0_ready", bus.s0_ready, (i % 2) == 0);
      check("alt.s1_ready", bus.s1_ready, (i % 2) == 1);
      push(1'((i % 2) == 1), ((i % 2) == 1) ? bus.s1_data : bus.s0_data);
      step();
      expect_out("alt");
    end

    // Output stall for five cycles with both requesters still pending.
    bus.m_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall.s0_ready", bus.s0_ready, 1'b0);
      check("stall.s1_ready", bus.s1_ready, 1'b0);
      step();
      check("stall.m_data", bus.m_data, last.data);
      check("stall.m_id", bus.m_id, last.id);
    end
`ifdef ZUC_SBOX_SCHED_STATS_EN
    check("cnt.stall", stall_cnt, 4'd5);
    check("cnt.grant1", grant_cnt1, 4'd3);
`endif

    // Drain and accept on the same edge: requester 0 has priority now.
    bus.m_ready = 1'b1;
    #1;
    check("drain.s0_ready", bus.s0_ready, 1'b1);
    push(1'b0, bus.s0_data);
    step();
    expect_out("drain");

    // Requester 0 alone, random words from the reference byte pool; counters saturate.
    bus.s1_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = {byte_pool[$urandom_range(0, 4)], byte_pool[$urandom_range(0, 4)],
           byte_pool[$urandom_range(0, 4)], byte_pool[$urandom_range(0, 4)]};
      bus.s0_data = w;
      #1;
      check("solo.s0_ready", bus.s0_ready, 1'b1);
      push(1'b0, w);
      step();
      expect_out("solo");
`ifdef ZUC_SBOX_SCHED_STATS_EN
      if (g0 == 10) check("cnt.grant0_10", grant_cnt0, 4'd10);
`endif
    end
`ifdef ZUC_SBOX_SCHED_STATS_EN
    check("cnt.grant0_sat", grant_cnt0, 4'd15);
    check("cnt.stall_hold", stall_cnt, 4'd5);
`endif

    // Asynchronous reset with a result pending.
    bus.s0_valid = 1'b0;
    bus.m_ready  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst.m_valid", bus.m_valid, 1'b0);
    check("arst.m_data", bus.m_data, 32'h0);
    check("arst.m_id", bus.m_id, 1'b0);
`ifdef ZUC_SBOX_SCHED_STATS_EN
    check("arst.grant0", grant_cnt0, 4'd0);
`endif
    sb.delete();
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    bus.m_ready  = 1'b1;
    #1;
    check("arst.s0_ready", bus.s0_ready, 1'b1);
    step();
    check("arst.no_fire", bus.m_valid, 1'b0);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    rst = 1'b0;
    step();
    check("post.no_result", bus.m_valid, 1'b0);

    // First contention after reset goes to requester 0, then requester 1.
    bus.s0_valid = 1'b1;
    bus.s1_valid = 1'b1;
    bus.s0_data  = 32'h8001_10ff;
    bus.s1_data  = 32'hff00_8001;
    #1;
    check("post.s0_ready", bus.s0_ready, 1'b1);
    check("post.s1_ready", bus.s1_ready, 1'b0);
    push(1'b0, bus.s0_data);
    step();
    expect_out("post0");
    check("post.s1_ready2", bus.s1_ready, 1'b1);
    push(1'b1, bus.s1_data);
    step();
    expect_out("post1");
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b0;
    check("sb.empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
